// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 16 ticks per bit, 3-sample majority vote at mid-bit,
// optional parity, valid/ready holding register and single-cycle error pulses.
module uart_rx_oversampled #(
    parameter int P_DATA_BITS       = 8,
    parameter int P_OVERSAMPLE_RATE = 16,
    parameter int P_PARITY_EN       = 0,
    parameter int P_PARITY_ODD      = 0
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst_n,
    input  logic                   i_oversample_tick,
    input  logic                   i_rx,
    output logic [P_DATA_BITS-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_frame_err,
    output logic                   o_parity_err,
    output logic                   o_overrun,
    output logic                   o_busy
);

    localparam logic [3:0] CNT_SAMPLE_A = 4'd7;
    localparam logic [3:0] CNT_SAMPLE_B = 4'd8;
    localparam logic [3:0] CNT_DECIDE   = 4'd9;
    localparam logic [3:0] CNT_LAST     = 4'(P_OVERSAMPLE_RATE - 1);
    localparam logic [3:0] LAST_BIT     = 4'(P_DATA_BITS - 1);
    localparam logic       PARITY_ODD   = (P_PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_bit(input logic [P_DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic                   rx_meta_r;
    logic                   rx_sync_r;
    state_t                 state_r;
    logic [3:0]             cnt_r;
    logic [3:0]             bit_cnt_r;
    logic                   samp_a_r;
    logic                   samp_b_r;
    logic                   bit_r;
    logic [P_DATA_BITS-1:0] shift_r;
    logic                   parity_bad_r;
    logic                   deliver_r;
    logic                   frame_pend_r;
    logic                   parity_pend_r;
    logic                   vote_s;

    // Third sample is taken live at the decision count, the other two were latched earlier.
    assign vote_s = majority3(samp_a_r, samp_b_r, rx_sync_r);

    // Two-flop synchroniser for the asynchronous line, idles high.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame FSM, tick counter and bit sampling; advances only on oversample ticks.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            bit_cnt_r     <= 4'd0;
            samp_a_r      <= 1'b1;
            samp_b_r      <= 1'b1;
            bit_r         <= 1'b1;
            shift_r       <= '0;
            parity_bad_r  <= 1'b0;
            deliver_r     <= 1'b0;
            frame_pend_r  <= 1'b0;
            parity_pend_r <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            deliver_r     <= 1'b0;
            frame_pend_r  <= 1'b0;
            parity_pend_r <= 1'b0;
            if (i_oversample_tick) begin
                cnt_r <= cnt_r + 4'd1;
                if (cnt_r == CNT_SAMPLE_A) begin
                    samp_a_r <= rx_sync_r;
                end
                if (cnt_r == CNT_SAMPLE_B) begin
                    samp_b_r <= rx_sync_r;
                end
                if (cnt_r == CNT_DECIDE) begin
                    bit_r <= vote_s;
                end
                case (state_r)
                    ST_IDLE: begin
                        cnt_r <= 4'd0;
                        if (!rx_sync_r) begin
                            state_r <= ST_START;
                            o_busy  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if ((cnt_r == CNT_DECIDE) && vote_s) begin
                            state_r <= ST_IDLE;
                            o_busy  <= 1'b0;
                        end else if (cnt_r == CNT_LAST) begin
                            state_r      <= ST_DATA;
                            bit_cnt_r    <= 4'd0;
                            parity_bad_r <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_r == CNT_LAST) begin
                            shift_r   <= {bit_r, shift_r[P_DATA_BITS-1:1]};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == LAST_BIT) begin
                                state_r <= (P_PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (cnt_r == CNT_LAST) begin
                            parity_bad_r <= (bit_r != parity_bit(shift_r, PARITY_ODD));
                            state_r      <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // Decide mid stop bit so a following start edge is never missed.
                        if (cnt_r == CNT_DECIDE) begin
                            if (vote_s) begin
                                if (parity_bad_r) begin
                                    parity_pend_r <= 1'b1;
                                end else begin
                                    deliver_r <= 1'b1;
                                end
                                state_r <= ST_IDLE;
                                o_busy  <= 1'b0;
                            end else begin
                                frame_pend_r <= 1'b1;
                                state_r      <= ST_BREAK_WAIT;
                            end
                        end
                    end
                    ST_BREAK_WAIT: begin
                        if (rx_sync_r) begin
                            state_r <= ST_IDLE;
                            o_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register with valid/ready handshake and registered error pulses.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_err  <= frame_pend_r;
            o_parity_err <= parity_pend_r;
            o_overrun    <= 1'b0;
            if (deliver_r) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shift_r;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench: an 8N1 and an 8E1 receiver driven with directed table vectors,
// hand-written corner sequences and random frames judged by a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, tick;
    logic       rx0, ready0, valid0, ferr0, perr0, ovr0, busy0;
    logic       rx1, ready1, valid1, ferr1, perr1, ovr1, busy1;
    logic [7:0] data0, data1;

    int tests = 0;
    int fails = 0;
    int tick_cnt = 0;
    int ferr_n0 = 0, perr_n0 = 0, ovr_n0 = 0, vtick0 = 0;
    int ferr_n1 = 0, perr_n1 = 0, ovr_n1 = 0, vtick1 = 0;
    logic valid0_d = 1'b0, valid1_d = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    uart_rx_oversampled #(.P_DATA_BITS(8), .P_OVERSAMPLE_RATE(16), .P_PARITY_EN(0), .P_PARITY_ODD(0)) u_8n1 (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_oversample_tick(tick), .i_rx(rx0),
        .o_data(data0), .o_valid(valid0), .i_ready(ready0), .o_frame_err(ferr0),
        .o_parity_err(perr0), .o_overrun(ovr0), .o_busy(busy0));

    uart_rx_oversampled #(.P_DATA_BITS(8), .P_OVERSAMPLE_RATE(16), .P_PARITY_EN(1), .P_PARITY_ODD(0)) u_8e1 (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_oversample_tick(tick), .i_rx(rx1),
        .o_data(data1), .o_valid(valid1), .i_ready(ready1), .o_frame_err(ferr1),
        .o_parity_err(perr1), .o_overrun(ovr1), .o_busy(busy1));

    // Oversample tick: one clock high out of every four.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(posedge clk) if (tick) tick_cnt <= tick_cnt + 1;

    // Monitor samples after all bench drives have settled following the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (ferr0) ferr_n0 <= ferr_n0 + 1;
        if (perr0) perr_n0 <= perr_n0 + 1;
        if (ovr0)  ovr_n0  <= ovr_n0 + 1;
        if (ferr1) ferr_n1 <= ferr_n1 + 1;
        if (perr1) perr_n1 <= perr_n1 + 1;
        if (ovr1)  ovr_n1  <= ovr_n1 + 1;
        if (valid0 && ready0) q0.push_back(data0);
        if (valid1 && ready1) q1.push_back(data1);
        if (valid0 && !valid0_d) vtick0 <= tick_cnt;
        if (valid1 && !valid1_d) vtick1 <= tick_cnt;
        valid0_d <= valid0;
        valid1_d <= valid1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    // Sends one frame, idles the line, then checks counted events against expectations.
    task automatic run_frame(input int sel, input logic [7:0] d, input logic par, input logic stop,
                             input int hold_low, input bit raise_ready, input int exp_hs,
                             input logic [7:0] exp_last, input int exp_f, input int exp_p,
                             input int exp_o, input string tag, input bit chk_lat);
        int f0, p0, o0, h0, st, lat, hs;
        bit raised;
        f0 = (sel == 0) ? ferr_n0 : ferr_n1;
        p0 = (sel == 0) ? perr_n0 : perr_n1;
        o0 = (sel == 0) ? ovr_n0  : ovr_n1;
        h0 = (sel == 0) ? q0.size() : q1.size();
        raised = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        set_rx(sel, 1'b0);
        st = tick_cnt;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            repeat (64) @(negedge clk);
        end
        if (sel == 1) begin
            set_rx(sel, par);
            repeat (64) @(negedge clk);
        end
        set_rx(sel, stop);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (raise_ready && !raised && !busy0) begin
                #1 ready0 = 1'b1;
                raised = 1'b1;
                @(negedge clk);
                #3;
                check({tag, " valid kept"}, valid0, 1'b1);
                check({tag, " data loaded"}, data0, exp_last);
            end
        end
        repeat (hold_low) @(negedge clk);
        set_rx(sel, 1'b1);
        repeat (192) @(negedge clk);
        #3;
        hs = ((sel == 0) ? q0.size() : q1.size()) - h0;
        check({tag, " handshakes"}, hs, exp_hs);
        if (exp_hs > 0 && hs > 0)
            check({tag, " data"}, (sel == 0) ? q0[$] : q1[$], exp_last);
        check({tag, " frame_err"}, ((sel == 0) ? ferr_n0 : ferr_n1) - f0, exp_f);
        check({tag, " parity_err"}, ((sel == 0) ? perr_n0 : perr_n1) - p0, exp_p);
        check({tag, " overrun"}, ((sel == 0) ? ovr_n0 : ovr_n1) - o0, exp_o);
        if (chk_lat) begin
            lat = ((sel == 0) ? vtick0 : vtick1) - st;
            if (sel == 0) check_range({tag, " latency"}, lat, 155, 156);
            else          check_range({tag, " latency"}, lat, 171, 172);
        end
    endtask

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         hold_low;
        int         exp_hs;
        int         exp_f;
        int         exp_p;
    } vec_t;

    initial begin
        vec_t vt[7];
        int   hsnap;
        logic [7:0] d;
        logic par, stop, good_par;
        int   sel;

        vt[0] = '{0, 8'hA5, 1'b0, 1'b1, 0,   1, 0, 0};
        vt[1] = '{0, 8'h3C, 1'b0, 1'b0, 160, 0, 1, 0};
        vt[2] = '{0, 8'h55, 1'b0, 1'b1, 0,   1, 0, 0};
        vt[3] = '{1, 8'h07, 1'b0, 1'b1, 0,   0, 0, 1};
        vt[4] = '{1, 8'h07, 1'b1, 1'b1, 0,   1, 0, 0};
        vt[5] = '{1, 8'h07, 1'b1, 1'b0, 0,   0, 1, 0};
        vt[6] = '{1, 8'h06, 1'b1, 1'b0, 0,   0, 1, 0};

        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        check("reset valid0", valid0, 1'b0);
        check("reset data0", data0, 8'h00);
        check("reset busy0", busy0, 1'b0);
        check("reset errs0", {ferr0, perr0, ovr0}, 3'b000);
        check("reset valid1", valid1, 1'b0);
        check("reset busy1", busy1, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (16) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_frame(vt[i].sel, vt[i].d, vt[i].par, vt[i].stop, vt[i].hold_low, 1'b0,
                      vt[i].exp_hs, vt[i].d, vt[i].exp_f, vt[i].exp_p, 0,
                      $sformatf("vec%0d", i), vt[i].exp_hs == 1);

        // False start: a 4-tick low glitch must not start a frame.
        hsnap = q0.size();
        @(negedge clk);
        rx0 = 1'b0;
        repeat (16) @(negedge clk);
        rx0 = 1'b1;
        repeat (4) @(negedge clk);
        #3 check("false start busy", busy0, 1'b1);
        repeat (44) @(negedge clk);
        #3 check("false start idle", busy0, 1'b0);
        repeat (128) @(negedge clk);
        #3 check("false start no byte", q0.size() - hsnap, 0);
        check("false start no err", {ferr0, perr0, valid0}, 3'b000);

        // Overrun, then a delivery coinciding with the consumer becoming ready.
        @(negedge clk);
        #1 ready0 = 1'b0;
        run_frame(0, 8'h11, 1'b0, 1'b1, 0, 1'b0, 0, 8'h11, 0, 0, 0, "ovr first", 1'b0);
        check("ovr hold valid", valid0, 1'b1);
        check("ovr hold data", data0, 8'h11);
        run_frame(0, 8'h22, 1'b0, 1'b1, 0, 1'b0, 0, 8'h11, 0, 0, 1, "ovr second", 1'b0);
        check("ovr keep data", data0, 8'h11);
        run_frame(0, 8'h33, 1'b0, 1'b1, 0, 1'b1, 2, 8'h33, 0, 0, 0, "ovr third", 1'b0);

        // Random frames judged by a frame-level model.
        for (int i = 0; i < 24; i++) begin
            sel  = i % 2;
            d    = 8'($urandom);
            par  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 7) != 0);
            good_par = (sel == 0) || (par == ^d);
            run_frame(sel, d, par, stop, 0, 1'b0, (stop && good_par) ? 1 : 0, d,
                      stop ? 0 : 1, (stop && !good_par) ? 1 : 0, 0,
                      $sformatf("rnd%0d", i), stop && good_par);
        end

        // Reset during data bit 4 after a known delivery.
        run_frame(0, 8'h5A, 1'b0, 1'b1, 0, 1'b0, 1, 8'h5A, 0, 0, 0, "pre reset", 1'b1);
        hsnap = q0.size();
        @(negedge clk);
        rx0 = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx0 = (i % 2 == 0);
            repeat (64) @(negedge clk);
        end
        rx0 = 1'b1;
        repeat (32) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst busy", busy0, 1'b0);
        check("midrst valid", valid0, 1'b0);
        check("midrst data", data0, 8'h00);
        check("midrst errs", {ferr0, perr0, ovr0}, 3'b000);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (192) @(negedge clk);
        #3 check("midrst no partial", q0.size() - hsnap, 0);
        check("midrst idle", busy0, 1'b0);
        run_frame(0, 8'h81, 1'b0, 1'b1, 0, 1'b0, 1, 8'h81, 0, 0, 0, "post reset", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Oversampling UART receiver that consumes the oversample tick from the baud rate generator and recovers 8N1 (optionally 8E1/8O1) frames from the asynchronous RX line. It synchronises the line, validates the start bit, majority-votes each bit at mid-period and delivers bytes through a valid/ready holding register. Framing, parity and overrun errors are reported as single-cycle pulses.

## Interface
- P_DATA_BITS, 8: data bits per frame, LSB first; legal range 5–8.
- P_OVERSAMPLE_RATE, 16: ticks per bit; fixed at 16, since the counter and sample points depend on it.
- P_PARITY_EN, 0: 1 inserts a parity bit between the data and stop bits.
- P_PARITY_ODD, 0: 1 selects odd parity and 0 selects even; ignored when P_PARITY_EN=0.

- i_sys_clk  input  1  system clock.
- i_sys_rst_n  input  1  asynchronous, active-low reset.
- i_oversample_tick  input  1  one-cycle pulse at 16× baud.
- i_rx  input  1  asynchronous serial line; idle high.
- o_data  output  P_DATA_BITS  received byte; stable while o_valid=1.
- o_valid  output  1  holding register full.
- i_ready  input  1  consumer accepts; a handshake occurs when o_valid & i_ready.
- o_frame_err  output  1  one-cycle pulse when the stop bit samples as 0.
- o_parity_err  output  1  one-cycle pulse when parity mismatches.
- o_overrun  output  1  one-cycle pulse when a good byte is dropped because the register is full.
- o_busy  output  1  high in every state except IDLE.

## Operation
- i_rx passes through a 2-flop synchroniser (reset value 1). All state below uses the synchronised value rx_s.
- The FSM, the 4-bit tick counter (0..15) and the samples advance only on clock edges where i_oversample_tick=1.
- On each bit, rx_s is captured at counts 7, 8 and 9. The bit value is the majority of the three samples.
- States and transitions:
  - IDLE: when rx_s=0 on a tick, clear the counter and go to START.
  - START: at count 9, a majority of 1 is a false start; return to IDLE with no error. Otherwise, at count 15, go to DATA.
  - DATA: at each count 15, shift the voted bit in LSB first. After P_DATA_BITS bits, go to PARITY if enabled, else go to STOP.
  - PARITY: at count 15, compare the voted bit with the computed parity, then go to STOP.
  - STOP: decision at count 9, not 15, so the receiver can resynchronise early.
    - Vote 1 with no parity error: deliver the byte and go to IDLE.
    - Vote 1 with a parity error: pulse o_parity_err, discard the byte and go to IDLE.
    - Vote 0: pulse o_frame_err, discard the byte and go to BREAK_WAIT.
  - BREAK_WAIT: go to IDLE on the first tick where rx_s=1. A held-low line (break) produces exactly one o_frame_err.
- Delivery rules:
  - o_valid=0, or a handshake in the same cycle: load o_data and set o_valid=1. A simultaneous handshake and new byte keeps o_valid=1 with no overrun.
  - o_valid=1 and i_ready=0: keep the old byte, drop the new one and pulse o_overrun.
- The handshake clears o_valid on the next edge.
- When both a parity error and a framing error occur, only o_frame_err pulses.

## Timing
- Reset values:
  - o_data=0, o_valid=0, o_frame_err=0, o_parity_err=0, o_overrun=0, o_busy=0.
  - FSM in IDLE, counter 0, synchroniser flops 1.
- Input latency: 2 clock cycles from i_rx to rx_s.
- Output latency: o_valid, o_data and the error pulses register on the edge after the STOP decision tick, i.e. 1 cycle.
- Frame length from start detection to decision:
  - 16·(1+P_DATA_BITS+P_PARITY_EN)+10 ticks.
  - 8N1: 154 ticks.
- The receiver is back in IDLE 6 ticks before the nominal stop-bit end. It tolerates a baud mismatch of ±3.5% for 8N1.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. A partial byte is never delivered.
- Edges without i_oversample_tick change no state except the synchroniser and the handshake/valid logic.

## Test plan
- Send 0xA5 as 8N1 at 16 ticks/bit with i_ready=1 -> o_data=0xA5, o_valid high for 1 cycle, 155 ticks after the start edge; no error pulses.
- Drive i_rx low for 4 ticks, then high -> the FSM returns to IDLE at count 9; o_valid=0, no errors, o_busy drops.
- Send 0x3C with the stop bit forced to 0, then hold the line low for 40 ticks, then release it and send 0x55 -> exactly one o_frame_err, 0x3C not delivered, 0x55 delivered.
- With i_ready=0, send 0x11 then 0x22 -> o_data holds 0x11, one o_overrun pulse. Raise i_ready in the same cycle as a third byte 0x33 completes -> 0x33 loaded, o_valid stays 1, no overrun.
- Set P_PARITY_EN=1, P_PARITY_ODD=0 and send 0x07 with parity bit 0 -> o_parity_err pulses and the byte is dropped. Resend with parity bit 1 -> 0x07 delivered.
- Assert i_sys_rst_n low during data bit 4 of a frame, release it, then send 0x81 -> no partial output; outputs at reset values; 0x81 received correctly.
